// File: rtl/ram_arbiter.sv
// Round-robin arbiter and sequencer placing two masters in front of one single-port synchronous RAM.
// Define RAM_ARB_CLEAR_EN to sweep the whole array with CLEAR_VAL after every reset.
module ram_arbiter #(
   parameter int ADDR_W    = 10,
   parameter int DATA_W    = 8,
   parameter int CLEAR_VAL = 8'h00
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic              ram_wr_en,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout
);

   if (CLEAR_VAL < 0 || (CLEAR_VAL >> DATA_W) != 0) begin : g_bad_clear_val
      $error("CLEAR_VAL does not fit in DATA_W bits");
   end

   logic              prio_q, prio_d;
   logic              rvalid0_q, rvalid1_q;
   logic              rvalid0_d, rvalid1_d;
   logic [DATA_W-1:0] rdata_q;
   logic              clearing;
   logic              arb_en;

`ifdef RAM_ARB_CLEAR_EN
   localparam logic [0:0] ARB   = 1'b0;
   localparam logic [0:0] CLEAR = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

   assign clearing = (state_q == CLEAR);

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      if (state_q == CLEAR) begin
         clr_cnt_d = clr_cnt_q + 1'b1;
         if (&clr_cnt_q) begin
            state_d = ARB;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= CLEAR;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end
`else
   assign clearing = 1'b0;
`endif

   assign busy   = clearing;
   assign arb_en = !rst && !clearing;

   // On contention the master named by prio wins; a lone requester always wins.
   assign gnt0 = arb_en && req0 && (!req1 || !prio_q);
   assign gnt1 = arb_en && req1 && (!req0 || prio_q);

   always_comb begin
      ram_wr_en = 1'b0;
      ram_addr  = '0;
      ram_din   = '0;
      if (gnt0) begin
         ram_wr_en = we0;
         ram_addr  = addr0;
         ram_din   = wdata0;
      end else if (gnt1) begin
         ram_wr_en = we1;
         ram_addr  = addr1;
         ram_din   = wdata1;
      end
`ifdef RAM_ARB_CLEAR_EN
      else if (clearing && !rst) begin
         ram_wr_en = 1'b1;
         ram_addr  = clr_cnt_q;
         ram_din   = DATA_W'(CLEAR_VAL);
      end
`endif
   end

   always_comb begin
      prio_d = prio_q;
      if (gnt0) begin
         prio_d = 1'b1;
      end else if (gnt1) begin
         prio_d = 1'b0;
      end
   end

   assign rvalid0_d = gnt0 && !we0;
   assign rvalid1_d = gnt1 && !we1;

   // The RAM output register already supplies the one-cycle latency; rdata_q only holds the last return.
   assign rdata   = (rvalid0_q || rvalid1_q) ? ram_dout : rdata_q;
   assign rvalid0 = rvalid0_q;
   assign rvalid1 = rvalid1_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         prio_q    <= 1'b0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         rdata_q   <= '0;
      end else begin
         prio_q    <= prio_d;
         rvalid0_q <= rvalid0_d;
         rvalid1_q <= rvalid1_d;
         rdata_q   <= rdata;
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: bench-side RAM, cycle-level behavioural model and directed scenarios.
// Set RAM_ARB_CLEAR_EN to also exercise the post-reset clear sweep.
module tb_ram_arbiter;
   localparam int ADDR_W = 10;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 1 << ADDR_W;
   localparam logic [7:0] CLR_V = 8'h00;
`ifdef RAM_ARB_CLEAR_EN
   localparam int SWEEP = DEPTH;
`else
   localparam int SWEEP = 0;
`endif

   logic clk = 1'b0;
   logic rst, req0, req1, we0, we1;
   logic [ADDR_W-1:0] addr0, addr1, ram_addr;
   logic [DATA_W-1:0] wdata0, wdata1, rdata, ram_din, ram_dout;
   logic gnt0, gnt1, rvalid0, rvalid1, busy, ram_wr_en;

   always #5 clk = ~clk;

   ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CLEAR_VAL(CLR_V)) dut (
      .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata(rdata), .busy(busy), .ram_wr_en(ram_wr_en), .ram_addr(ram_addr),
      .ram_din(ram_din), .ram_dout(ram_dout)
   );

   // Single-port RAM with synchronous read, as it sits behind the arbiter.
   logic [DATA_W-1:0] ram_mem [DEPTH];
   always @(posedge clk) begin
      if (ram_wr_en) ram_mem[ram_addr] <= ram_din;
      ram_dout <= ram_mem[ram_addr];
   end

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: what the array should hold, who was served last, and what return is owed.
   logic [DATA_W-1:0] model_mem [DEPTH];
   bit                armed = 0;
   int                last_winner;
   bit                ret_pending;
   int                ret_master;
   logic [DATA_W-1:0] ret_data;
   logic [DATA_W-1:0] rdata_exp;
   int                sweep_left;
   int                grant_log[$];
   logic [8:0]        rd_log[$];

   always @(negedge clk) begin
      int winner;
      if (armed) begin
         chk("rvalid0", rvalid0, ret_pending && ret_master == 0);
         chk("rvalid1", rvalid1, ret_pending && ret_master == 1);
         if (ret_pending) rdata_exp = ret_data;
         chk("rdata", rdata, rdata_exp);
         if (rvalid0 || rvalid1) begin
            rd_log.push_back({rvalid1, rdata});
            $display("ret m%0d data=%02h", rvalid1 ? 1 : 0, rdata);
         end
      end
      ret_pending = 0;
      if (rst) begin
         if (armed) begin
            chk("rst_gnt0", gnt0, 0);
            chk("rst_gnt1", gnt1, 0);
            chk("rst_wr_en", ram_wr_en, 0);
         end
         armed       = 1;
         last_winner = 1;
         sweep_left  = SWEEP;
         rdata_exp   = '0;
      end else if (armed && sweep_left > 0) begin
         chk("sweep_busy", busy, 1);
         chk("sweep_gnt0", gnt0, 0);
         chk("sweep_gnt1", gnt1, 0);
         chk("sweep_wr_en", ram_wr_en, 1);
         chk("sweep_addr", ram_addr, DEPTH - sweep_left);
         chk("sweep_din", ram_din, CLR_V);
         model_mem[DEPTH - sweep_left] = CLR_V;
         sweep_left--;
      end else if (armed) begin
         chk("busy", busy, 0);
         winner = -1;
         if (req0 && req1) winner = 1 - last_winner;
         else if (req0) winner = 0;
         else if (req1) winner = 1;
         chk("gnt0", gnt0, winner == 0);
         chk("gnt1", gnt1, winner == 1);
         if (winner >= 0) begin
            logic              w;
            logic [ADDR_W-1:0] a;
            logic [DATA_W-1:0] d;
            w = (winner == 0) ? we0 : we1;
            a = (winner == 0) ? addr0 : addr1;
            d = (winner == 0) ? wdata0 : wdata1;
            chk("ram_wr_en", ram_wr_en, w);
            chk("ram_addr", ram_addr, a);
            if (w) begin
               chk("ram_din", ram_din, d);
               model_mem[a] = d;
            end else begin
               ret_pending = 1;
               ret_master  = winner;
               ret_data    = model_mem[a];
            end
            last_winner = winner;
            $display("gnt m%0d %s addr=%0d data=%02h", winner, w ? "wr" : "rd", a, d);
         end else begin
            chk("idle_wr_en", ram_wr_en, 0);
            chk("idle_addr", ram_addr, 0);
            chk("idle_din", ram_din, 0);
         end
         grant_log.push_back(winner);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      req0 = 0; req1 = 0; we0 = 0; we1 = 0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (busy && n < 3000) begin
         cyc();
         n++;
      end
      chk("ready_bound", busy, 0);
   endtask

   task automatic reset_and_wait(output int n);
      rst = 1;
      cyc();
      cyc();
      rst = 0;
      wait_ready(n);
   endtask

   initial begin
      int n, g0, r0;
      for (int i = 0; i < DEPTH; i++) begin
         ram_mem[i]   = 8'(i) ^ 8'h5A;
         model_mem[i] = 8'(i) ^ 8'h5A;
      end
      rst = 1;
      idle();
      reset_and_wait(n);
      chk("sweep_len", n, SWEEP);
      cyc();

`ifdef RAM_ARB_CLEAR_EN
      // Reset pulsed mid-sweep while master 1 waits to read address 5.
      rst = 1;
      cyc();
      rst = 0;
      req1 = 1; we1 = 0; addr1 = 10'd5;
      repeat (500) cyc();
      rst = 1;
      cyc();
      rst = 0;
      wait_ready(n);
      chk("restart_len", n, 1024);
      r0 = rd_log.size();
      cyc();
      idle();
      cyc();
      cyc();
      chk("clear_rd_n", rd_log.size() - r0, 1);
      if (rd_log.size() > r0) chk("clear_rd", rd_log[r0], {1'b1, 8'h00});
`endif

      // Lone master: ten writes then ten reads, all on consecutive cycles.
      g0 = grant_log.size();
      r0 = rd_log.size();
      for (int i = 0; i < 10; i++) begin
         req0 = 1; we0 = 1; addr0 = 10'(i); wdata0 = 8'(2 * i);
         cyc();
      end
      for (int i = 0; i < 10; i++) begin
         we0 = 0; addr0 = 10'(i);
         cyc();
      end
      idle();
      cyc();
      cyc();
      for (int i = 0; i < 20; i++)
         if (g0 + i < grant_log.size()) chk("single_gnt", grant_log[g0 + i], 0);
      chk("single_rd_n", rd_log.size() - r0, 10);
      for (int i = 0; i < 10; i++)
         if (r0 + i < rd_log.size()) chk("single_rd", rd_log[r0 + i], {1'b0, 8'(2 * i)});

      // Contention straight from reset: strict alternation starting with master 0.
      reset_and_wait(n);
      g0 = grant_log.size();
      req0 = 1; we0 = 1; addr0 = 10'd3; wdata0 = 8'd6;
      req1 = 1; we1 = 1; addr1 = 10'd4; wdata1 = 8'd8;
      repeat (6) cyc();
      idle();
      cyc();
      for (int i = 0; i < 6; i++)
         if (g0 + i < grant_log.size()) chk("contend_order", grant_log[g0 + i], i % 2);

      // Priority update: master 1 alone, then both.
      g0 = grant_log.size();
      req1 = 1; we1 = 0; addr1 = 10'd4;
      cyc();
      req0 = 1; we0 = 0; addr0 = 10'd3;
      cyc();
      cyc();
      idle();
      cyc();
      cyc();
      if (g0 + 2 < grant_log.size()) begin
         chk("prio_g0", grant_log[g0], 1);
         chk("prio_g1", grant_log[g0 + 1], 0);
         chk("prio_g2", grant_log[g0 + 2], 1);
      end

      // Return steering across masters on back-to-back reads.
      r0 = rd_log.size();
      req0 = 1; we0 = 0; addr0 = 10'd3;
      cyc();
      req0 = 0;
      req1 = 1; we1 = 0; addr1 = 10'd4;
      cyc();
      idle();
      cyc();
      cyc();
      chk("steer_n", rd_log.size() - r0, 2);
      if (rd_log.size() > r0 + 1) begin
         chk("steer_m0", rd_log[r0], {1'b0, 8'd6});
         chk("steer_m1", rd_log[r0 + 1], {1'b1, 8'd8});
      end

      // A read presented during reset must not produce a return.
      rst = 1;
      req0 = 1; we0 = 0; addr0 = 10'd7;
      cyc();
      chk("rst_no_rvalid", rvalid0, 0);
      rst = 0;
      idle();
      wait_ready(n);
      cyc();
      cyc();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester round-robin arbiter and sequencer for the single-port 1K×8 RAM (`wr_en`, `clk`, `rst`, `data_in`, `address`, `data_out`).
- Shares the one RAM port between two masters, one access per cycle.
- Returns read data to the issuing master with a per-master valid strobe.
- Optionally sweeps the whole array to a known value after reset.

The block sits directly in front of the RAM instance. The RAM's ports connect straight to the `ram_*` ports below.

## Interface
Parameters:
- `ADDR_W`, 10, RAM address width; array depth is 2^ADDR_W.
- `DATA_W`, 8, RAM data width.
- `CLEAR_VAL`, 8'h00, value written by the clear sweep (used only with `RAM_ARB_CLEAR_EN`).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0`, `req1`  in  1  access request from master 0 / master 1.
- `we0`, `we1`  in  1  1 = write, 0 = read; qualified by `reqN`.
- `addr0`, `addr1`  in  ADDR_W  access address.
- `wdata0`, `wdata1`  in  DATA_W  write data.
- `gnt0`, `gnt1`  out  1  combinational grant; the access is performed in this cycle.
- `rvalid0`, `rvalid1`  out  1  registered; read data for master N is on `rdata`.
- `rdata`  out  DATA_W  registered read-return bus shared by both masters.
- `busy`  out  1  clear sweep in progress; no grants are issued while high.
- `ram_wr_en`  out  1  to RAM `wr_en`.
- `ram_addr`  out  ADDR_W  to RAM `address`.
- `ram_din`  out  DATA_W  to RAM `data_in`.
- `ram_dout`  in  DATA_W  from RAM `data_out`; the RAM has synchronous read with 1-cycle latency.

## Operation
- State machine: `ARB` (normal arbitration) and `CLEAR` (only with the macro). Register `prio` (0/1) names the master with priority.
- In `ARB`, each cycle:
  - Neither `reqN` high: no grant. `ram_wr_en=0`, `ram_addr=0`, `ram_din=0`.
  - Exactly one `reqN` high: grant that master.
  - Both high: grant master `prio`.
- On a grant to master g:
  - `gnt_g=1`.
  - `ram_wr_en=we_g`, `ram_addr=addr_g`, `ram_din=wdata_g`.
  - At the clock edge, `prio` is set to the other master (`prio <= ~g`).
  - With no grant, `prio` holds.
- At most one `gntN` is high in any cycle. `gnt0 & gnt1` is never 1.
- Masters hold `req`/`we`/`addr`/`wdata` stable until they see `gnt`. A master may issue a new request in the cycle after its grant.
- Read return: a granted read in cycle N produces `rvalid_g=1` and `rdata=ram_dout` in cycle N+1 for exactly one cycle.
  - `rdata` holds its last value when no `rvalid` is high.
  - A granted write produces no `rvalid`.
- `CLEAR`:
  - `ram_wr_en=1`, `ram_addr=clr_cnt`, `ram_din=CLEAR_VAL`.
  - `gnt0=gnt1=0`, `busy=1`.
  - `clr_cnt` increments each cycle. The write of address 2^ADDR_W−1 is the last `CLEAR` cycle, and the next cycle is `ARB`.
  - Requests raised during `CLEAR` stay pending and are served from the first `ARB` cycle.

## Timing
- Reset values (cycle after `rst` sampled high):
  - `prio=0`, `rvalid0=rvalid1=0`, `rdata=0`, `clr_cnt=0`.
  - State is `CLEAR` with the macro, otherwise `ARB`.
  - `busy` is 1 with the macro, otherwise 0.
- While `rst=1`: `gnt0=gnt1=0` and `ram_wr_en=0`.
- Grant latency is 0 cycles (combinational from `req` and `prio`). Read data latency is 1 cycle after the grant.
- Throughput is one access per cycle.
  - A lone continuously requesting master is granted every cycle.
  - Two continuously requesting masters alternate strictly, starting with `prio`.
- Reset asserted mid-operation:
  - Any read granted in the reset cycle returns no `rvalid`.
  - With the macro, a clear sweep in progress restarts from address 0.
- Sweep duration is exactly 2^ADDR_W cycles (1024 at defaults). `busy` falls in the same cycle the state becomes `ARB`.
- Back-to-back reads by alternating masters give consecutive `rvalid0`/`rvalid1` pulses on the shared `rdata`, each one cycle after its grant.

## Configuration
- `RAM_ARB_CLEAR_EN` defined:
  - The `CLEAR` state, `clr_cnt` and `CLEAR_VAL` logic are compiled in.
  - Every reset is followed by a full-array sweep writing `CLEAR_VAL`.
- `RAM_ARB_CLEAR_EN` undefined:
  - No `CLEAR` state; `busy` is tied to 0.
  - The first `ARB` cycle is the cycle after `rst` deasserts.
  - RAM contents after reset are unchanged.

## Test plan
- Reset then idle, with the macro: `busy=1` for 1024 cycles, `ram_wr_en=1` with `ram_addr` counting 0..1023 and `ram_din=8'h00`. Afterwards a read of address 5 returns `rdata=8'h00`.
- Single master: master 0 writes `addr=i`, `wdata=2*i` for i=0..9 on consecutive cycles, then reads i=0..9. Required: `gnt0` high every cycle, and `rvalid0` one cycle after each read with `rdata=2*i`.
- Contention: `req0=req1=1` continuously for 6 cycles from reset (`prio=0`). Required grant order 0,1,0,1,0,1; `gnt0 & gnt1` is never 1.
- Priority update: `req1` alone for 1 cycle, then both masters. Required: `gnt1`, then `gnt0`, then `gnt1`.
- Read return steering: master 0 reads addr 3 (holding 6) and master 1 reads addr 4 (holding 8) in consecutive cycles. Required: `rvalid0` with `rdata=6`, then `rvalid1` with `rdata=8`.
- Reset mid-sweep, with the macro: `rst` pulsed at sweep cycle 500. Required: `clr_cnt` restarts at 0, `busy` stays high for a further 1024 cycles, and no grants are issued during the sweep.
